// File: rtl/regfile_dump.sv
// regfile_dump: debug reader that walks a register file through one combinational read
// port and streams each (address, value) pair out on a valid/ready interface.
//
// Parameters:
//   FIRST_REG  first register address dumped (0..31)
//   LAST_REG   last register address dumped (FIRST_REG..31)
//
// Ports:
//   Clk           rising-edge clock
//   Reset         synchronous active-high reset; aborts a dump in flight
//   Start         begin a dump, honoured only while idle
//   Busy          high from the cycle after an accepted Start until Done
//   Done          one-cycle pulse after the final beat handshakes
//   ReadRegister  address to the register file read port
//   ReadData      register file data for ReadRegister
//   DumpAddr      register address of the current beat
//   DumpData      captured register value of the current beat
//   DumpValid     beat valid
//   DumpReady     sink accepts the beat when DumpValid & DumpReady at a Clk edge
//   Checksum      (REGDUMP_CHECKSUM_EN only) mod-2^32 sum of DumpData over accepted beats
//
// Optional feature macro: REGDUMP_CHECKSUM_EN adds the Checksum output and its adder.

module regfile_dump #(
  parameter int unsigned FIRST_REG = 0,
  parameter int unsigned LAST_REG  = 31
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  output logic        Busy,
  output logic        Done,
  output logic [4:0]  ReadRegister,
  input  logic [31:0] ReadData,
  output logic [4:0]  DumpAddr,
  output logic [31:0] DumpData,
  output logic        DumpValid,
  input  logic        DumpReady
`ifdef REGDUMP_CHECKSUM_EN
  ,
  output logic [31:0] Checksum
`endif
);

  if (FIRST_REG > LAST_REG) begin : gen_bad_range
    $error("regfile_dump: FIRST_REG must not exceed LAST_REG");
  end
  if (LAST_REG > 31) begin : gen_bad_last
    $error("regfile_dump: LAST_REG must be at most 31");
  end

  localparam logic [4:0] FirstAddr = 5'(FIRST_REG);
  localparam logic [4:0] LastAddr  = 5'(LAST_REG);

  typedef enum logic [1:0] {StIdle, StRead, StSend, StFin} state_e;

  state_e      state_q, state_d;
  logic [4:0]  addr_q, addr_d;
  logic        busy_q, busy_d;
  logic [4:0]  dump_addr_q, dump_addr_d;
  logic [31:0] dump_data_q, dump_data_d;
  logic        valid_q, valid_d;

`ifdef REGDUMP_CHECKSUM_EN
  logic [31:0] sum_q, sum_d;
`endif

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    busy_d      = busy_q;
    dump_addr_d = dump_addr_q;
    dump_data_d = dump_data_q;
    valid_d     = valid_q;
`ifdef REGDUMP_CHECKSUM_EN
    sum_d       = sum_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (Start) begin
          state_d = StRead;
          addr_d  = FirstAddr;
          busy_d  = 1'b1;
`ifdef REGDUMP_CHECKSUM_EN
          sum_d   = '0;
`endif
        end
      end
      StRead: begin
        dump_addr_d = addr_q;
        dump_data_d = ReadData;
        valid_d     = 1'b1;
        state_d     = StSend;
      end
      StSend: begin
        if (DumpReady) begin
          valid_d = 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
          sum_d   = sum_q + dump_data_q;
`endif
          // Compare before incrementing so the address never wraps past 31.
          if (addr_q == LastAddr) begin
            state_d = StFin;
          end else begin
            addr_d  = addr_q + 5'd1;
            state_d = StRead;
          end
        end
      end
      StFin: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= StIdle;
      addr_q      <= FirstAddr;
      busy_q      <= 1'b0;
      dump_addr_q <= '0;
      dump_data_q <= '0;
      valid_q     <= 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
      sum_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      busy_q      <= busy_d;
      dump_addr_q <= dump_addr_d;
      dump_data_q <= dump_data_d;
      valid_q     <= valid_d;
`ifdef REGDUMP_CHECKSUM_EN
      sum_q       <= sum_d;
`endif
    end
  end

  assign ReadRegister = addr_q;
  assign Busy         = busy_q;
  assign Done         = (state_q == StFin);
  assign DumpAddr     = dump_addr_q;
  assign DumpData     = dump_data_q;
  assign DumpValid    = valid_q;
`ifdef REGDUMP_CHECKSUM_EN
  assign Checksum     = sum_q;
`endif

endmodule
